rtc_bus_sequencer: RTL and testbench

- Parametrised bus-cycle engine for the multiplexed address/data RTC interface (active-low CS/RD/WR; AD selects address or data).
- Successor to the single-shot clock programmer. Runs a burst of N consecutive register transfers, in write or read mode, from a start address.
- Bus timing is parametrised. The sequencer sits between the clock-control FSM (which supplies the register image) and the RTC pins.

---
 rtl/rtc_bus_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - burst bus-cycle engine for a multiplexed address/data RTC interface
//
// Runs Cantidad consecutive register transfers (write or read) starting at
// Dir_Inicio. Each transfer is an address phase followed by a data phase, and
// each phase is setup / strobe / hold. Transfers are separated by T_GAP cycles
// with CS released. All outputs are registered and decoded from the next state.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   Inicie            start request (rising edge, accepted only when idle)
//   Modo              0 = write burst, 1 = read burst (latched at start)
//   Dir_Inicio        first register address (latched at start)
//   Cantidad          number of transfers (latched at start)
//   Dato_Escr         write data for the current Indice (parent lookup)
//   Indice            index of the current transfer
//   Bus_Out, Bus_OE   value and output enable for the AD pins
//   Bus_In            value sampled from the AD pins
//   AD, RD, WR, CS    bus control (AD 0 = address; RD/WR/CS active low)
//   Dato_Leido        last captured read data
//   Dato_Valido       one-cycle pulse when Dato_Leido is updated
//   Ocupado           busy from the first burst cycle through DONE
//   Listo             one-cycle pulse at burst end
module rtc_bus_sequencer #(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 4,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Inicie,
    input  logic              Modo,
    input  logic [DATA_W-1:0] Dir_Inicio,
    input  logic [CNT_W-1:0]  Cantidad,
    input  logic [DATA_W-1:0] Dato_Escr,
    output logic [CNT_W-1:0]  Indice,
    output logic [DATA_W-1:0] Bus_Out,
    input  logic [DATA_W-1:0] Bus_In,
    output logic              Bus_OE,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    output logic              CS,
    output logic [DATA_W-1:0] Dato_Leido,
    output logic              Dato_Valido,
    output logic              Ocupado,
    output logic              Listo
);

    localparam int T_MAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int T_MAX_SG = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
    localparam int T_MAX    = (T_MAX_SH > T_MAX_SG) ? T_MAX_SH : T_MAX_SG;
    // The counter only ever holds (duration - 1).
    localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              inicie_prev_q, inicie_prev_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cant_q, cant_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic [DATA_W-1:0] leido_q, leido_d;
    logic              valido_q, valido_d;
    logic              oe_q, oe_d;
    logic              ad_q, ad_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              cs_q, cs_d;
    logic              ocup_q, ocup_d;
    logic              listo_q, listo_d;

    logic              last;
    logic              a_ph;
    logic              d_ph;

    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        inicie_prev_d = Inicie;
        mode_d        = mode_q;
        addr_d        = addr_q;
        cant_d        = cant_q;
        idx_d         = idx_q;
        bus_out_d     = bus_out_q;
        leido_d       = leido_q;
        valido_d      = 1'b0;
        last          = (tcnt_q == '0);

        case (state_q)
            IDLE: begin
                if (Inicie && !inicie_prev_q) begin
                    mode_d = Modo;
                    addr_d = Dir_Inicio;
                    cant_d = Cantidad;
                    idx_d  = '0;
                    if (Cantidad == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = A_SET;
                        tcnt_d  = TW'(T_SETUP - 1);
                    end
                end
            end
            A_SET: begin
                if (last) begin
                    state_d = A_STB;
                    tcnt_d  = TW'(T_STROBE - 1);
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            A_STB: begin
                if (last) begin
                    state_d = A_HLD;
                    tcnt_d  = TW'(T_HOLD - 1);
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            A_HLD: begin
                if (last) begin
                    state_d = D_SET;
                    tcnt_d  = TW'(T_SETUP - 1);
                    // Write data is frozen here and held through the data phase.
                    if (!mode_q) begin
                        bus_out_d = Dato_Escr;
                    end
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            D_SET: begin
                if (last) begin
                    state_d = D_STB;
                    tcnt_d  = TW'(T_STROBE - 1);
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            D_STB: begin
                if (last) begin
                    state_d = D_HLD;
                    tcnt_d  = TW'(T_HOLD - 1);
                    if (mode_q) begin
                        leido_d  = Bus_In;
                        valido_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            D_HLD: begin
                if (last) begin
                    if (idx_q == cant_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
                        tcnt_d  = TW'(T_GAP - 1);
                        idx_d   = idx_q + CNT_W'(1);
                        addr_d  = addr_q + DATA_W'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            GAP: begin
                if (last) begin
                    state_d = A_SET;
                    tcnt_d  = TW'(T_SETUP - 1);
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin decode from the next state so every output is a plain flop.
        a_ph     = (state_d == A_SET) || (state_d == A_STB) || (state_d == A_HLD);
        d_ph     = (state_d == D_SET) || (state_d == D_STB) || (state_d == D_HLD);
        cs_d     = !(a_ph || d_ph);
        ad_d     = !a_ph;
        oe_d     = a_ph || (d_ph && !mode_d);
        wr_d     = !((state_d == A_STB) || ((state_d == D_STB) && !mode_d));
        rd_d     = !((state_d == D_STB) && mode_d);
        ocup_d   = (state_d != IDLE);
        listo_d  = (state_d == DONE);
        if (a_ph) begin
            bus_out_d = addr_d;
        end else if (!(d_ph && !mode_d)) begin
            bus_out_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            inicie_prev_q <= 1'b0;
            mode_q        <= 1'b0;
            addr_q        <= '0;
            cant_q        <= '0;
            idx_q         <= '0;
            bus_out_q     <= '0;
            leido_q       <= '0;
            valido_q      <= 1'b0;
            oe_q          <= 1'b0;
            ad_q          <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            cs_q          <= 1'b1;
            ocup_q        <= 1'b0;
            listo_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            inicie_prev_q <= inicie_prev_d;
            mode_q        <= mode_d;
            addr_q        <= addr_d;
            cant_q        <= cant_d;
            idx_q         <= idx_d;
            bus_out_q     <= bus_out_d;
            leido_q       <= leido_d;
            valido_q      <= valido_d;
            oe_q          <= oe_d;
            ad_q          <= ad_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cs_q          <= cs_d;
            ocup_q        <= ocup_d;
            listo_q       <= listo_d;
        end
    end

    assign Indice      = idx_q;
    assign Bus_Out     = bus_out_q;
    assign Bus_OE      = oe_q;
    assign AD          = ad_q;
    assign RD          = rd_q;
    assign WR          = wr_q;
    assign CS          = cs_q;
    assign Dato_Leido  = leido_q;
    assign Dato_Valido = valido_q;
    assign Ocupado     = ocup_q;
    assign Listo       = listo_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - directed bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Inicie;
    logic       Modo;
    logic [7:0] Dir_Inicio;
    logic [3:0] Cantidad;
    logic [7:0] Dato_Escr;
    logic [3:0] Indice;
    logic [7:0] Bus_Out;
    logic [7:0] Bus_In;
    logic       Bus_OE, AD, RD, WR, CS;
    logic [7:0] Dato_Leido;
    logic       Dato_Valido, Ocupado, Listo;

    always #5 Clock = ~Clock;

    rtc_bus_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Inicie(Inicie), .Modo(Modo),
        .Dir_Inicio(Dir_Inicio), .Cantidad(Cantidad), .Dato_Escr(Dato_Escr),
        .Indice(Indice), .Bus_Out(Bus_Out), .Bus_In(Bus_In), .Bus_OE(Bus_OE),
        .AD(AD), .RD(RD), .WR(WR), .CS(CS), .Dato_Leido(Dato_Leido),
        .Dato_Valido(Dato_Valido), .Ocupado(Ocupado), .Listo(Listo)
    );

    // Register image and RTC read model.
    logic [7:0] tb_addr = 8'h00;
    assign Dato_Escr = 8'h10 + 8'(Indice);
    assign Bus_In    = tb_addr ^ 8'hFF;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge Clock) cyc++;

    // Bus monitor, sampled on the falling edge.
    int         listo_cnt = 0, listo_cyc = 0, ocup_cnt = 0, cs_low_cnt = 0;
    int         dp_bad = 0, proto_viol = 0, wr_run = 0, cs_hi_run = 0;
    logic       tb_rmode = 1'b0;
    logic       cs_p = 1'b1, wr_p = 1'b1, rd_p = 1'b1, ad_p = 1'b1;
    logic       strb, strb_p;
    logic [8:0] wr_ev[$];
    int         wr_len[$];
    int         gaps[$];
    logic [7:0] rd_data[$];

    always @(negedge Clock) begin
        if (Listo) begin
            listo_cnt++;
            listo_cyc = cyc;
        end
        if (Ocupado) ocup_cnt++;
        if (!CS) cs_low_cnt++;
        if (!WR && wr_p) wr_ev.push_back({AD, Bus_Out});
        if (!WR) wr_run++;
        else if (!wr_p) begin
            wr_len.push_back(wr_run);
            wr_run = 0;
        end
        if (!Ocupado) cs_hi_run = 0;
        else if (CS) cs_hi_run++;
        else begin
            if (cs_p && cs_hi_run > 0) gaps.push_back(cs_hi_run);
            cs_hi_run = 0;
        end
        if (Dato_Valido) rd_data.push_back(Dato_Leido);
        if (tb_rmode && !CS && AD && (Bus_OE || !WR)) dp_bad++;
        if (!CS && !AD) tb_addr = Bus_Out;
        strb   = !RD || !WR;
        strb_p = !rd_p || !wr_p;
        if ((!RD && !WR) || (CS && strb) || (strb && strb_p && AD != ad_p)) proto_viol++;
        cs_p = CS;
        wr_p = WR;
        rd_p = RD;
        ad_p = AD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses Inicie for one cycle; sc is the start cycle.
    task automatic start_burst(input logic m, input logic [7:0] d, input logic [3:0] c,
                               output int sc);
        Modo       = m;
        Dir_Inicio = d;
        Cantidad   = c;
        Inicie     = 1'b1;
        sc         = cyc;
        @(posedge Clock);
        #1;
        Inicie = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    int         s, b, l0, o0, c0, bl, bg, br, exp_len;
    logic       m;
    logic [7:0] d;
    logic [3:0] c;
    logic [8:0] exp_wr1[6] = '{9'h021, 9'h110, 9'h022, 9'h111, 9'h023, 9'h112};
    logic [8:0] exp_wrap[4] = '{9'h0FF, 9'h110, 9'h000, 9'h111};
    logic [8:0] exp_x[4] = '{9'h060, 9'h110, 9'h061, 9'h111};

    initial begin
        // Write burst started by Inicie held high out of reset.
        Reset = 1'b1; Inicie = 1'b1; Modo = 1'b0; Dir_Inicio = 8'h21; Cantidad = 4'd3;
        wait_cycles(2);
        check("rst_ctl", 32'({CS, RD, WR, AD, Bus_OE}), 32'h1E);
        check("rst_bus", 32'(Bus_Out), 0);
        check("rst_idx", 32'(Indice), 0);
        check("rst_leido", 32'(Dato_Leido), 0);
        check("rst_flags", 32'({Dato_Valido, Ocupado, Listo}), 0);
        Reset = 1'b0;
        s = cyc; b = wr_ev.size(); l0 = listo_cnt; o0 = ocup_cnt;
        bl = wr_len.size(); bg = gaps.size();
        wait_cycles(35);
        check("w_listo_cnt", listo_cnt - l0, 1);
        check("w_listo_lat", listo_cyc - s, 29);
        check("w_ocupado", ocup_cnt - o0, 29);
        check("w_nstrobes", wr_ev.size() - b, 6);
        for (int i = 0; i < 6; i++) check("w_pair", 32'(wr_ev[b+i]), 32'(exp_wr1[i]));
        for (int i = 0; i < 6; i++) check("w_wrlen", wr_len[bl+i], 2);
        check("w_ngaps", gaps.size() - bg, 2);
        for (int i = 0; i < 2; i++) check("w_gap", gaps[bg+i], 2);
        Inicie = 1'b0;
        wait_cycles(1);

        // Read burst.
        tb_rmode = 1'b1;
        b = wr_ev.size(); l0 = listo_cnt; br = rd_data.size();
        start_burst(1'b1, 8'h41, 4'd2, s);
        wait_cycles(25);
        check("r_listo_cnt", listo_cnt - l0, 1);
        check("r_listo_lat", listo_cyc - s, 19);
        check("r_nvalid", rd_data.size() - br, 2);
        check("r_data0", 32'(rd_data[br]), 32'hBE);
        check("r_data1", 32'(rd_data[br+1]), 32'hBD);
        check("r_dphase", dp_bad, 0);
        check("r_nstrobes", wr_ev.size() - b, 2);
        check("r_addr0", 32'(wr_ev[b]), 32'h041);
        check("r_addr1", 32'(wr_ev[b+1]), 32'h042);
        tb_rmode = 1'b0;

        // Address wrap.
        b = wr_ev.size(); l0 = listo_cnt;
        start_burst(1'b0, 8'hFF, 4'd2, s);
        wait_cycles(25);
        check("wrap_listo", listo_cnt - l0, 1);
        for (int i = 0; i < 4; i++) check("wrap_pair", 32'(wr_ev[b+i]), 32'(exp_wrap[i]));

        // Empty burst.
        l0 = listo_cnt; o0 = ocup_cnt; c0 = cs_low_cnt;
        start_burst(1'b0, 8'h70, 4'd0, s);
        wait_cycles(5);
        check("z_listo_cnt", listo_cnt - l0, 1);
        check("z_listo_lat", listo_cyc - s, 1);
        check("z_ocupado", ocup_cnt - o0, 1);
        check("z_cs_low", cs_low_cnt - c0, 0);

        // Reset during the second transfer's data strobe, then a clean burst.
        l0 = listo_cnt;
        start_burst(1'b0, 8'h30, 4'd3, s);
        wait_cycles(15);
        check("a_in_dstb", 32'({WR, AD}), 32'h1);
        check("a_idx", 32'(Indice), 1);
        Reset = 1'b1;
        wait_cycles(1);
        check("a_idle", 32'({CS, RD, WR, AD, Bus_OE, Ocupado}), 32'h3C);
        Reset = 1'b0;
        wait_cycles(1);
        b = wr_ev.size();
        start_burst(1'b0, 8'h50, 4'd1, s);
        check("a_restart_idx", 32'(Indice), 0);
        check("a_restart_ph", 32'({CS, AD}), 0);
        check("a_restart_bus", 32'(Bus_Out), 32'h50);
        wait_cycles(15);
        check("a_listo", listo_cnt - l0, 1);
        check("a_pair0", 32'(wr_ev[b]), 32'h050);
        check("a_pair1", 32'(wr_ev[b+1]), 32'h110);

        // Extra start and input changes mid-burst are ignored.
        b = wr_ev.size(); l0 = listo_cnt;
        start_burst(1'b0, 8'h60, 4'd2, s);
        wait_cycles(4);
        Inicie = 1'b1; Modo = 1'b1; Dir_Inicio = 8'h99; Cantidad = 4'd5;
        wait_cycles(2);
        Inicie = 1'b0;
        wait_cycles(30);
        check("x_listo_cnt", listo_cnt - l0, 1);
        check("x_listo_lat", listo_cyc - s, 19);
        for (int i = 0; i < 4; i++) check("x_pair", 32'(wr_ev[b+i]), 32'(exp_x[i]));

        // Random mix under the protocol monitor.
        for (int k = 0; k < 6; k++) begin
            m = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            c = 4'($urandom_range(0, 4));
            exp_len = (c == 0) ? 1 : 8 * int'(c) + 2 * (int'(c) - 1) + 1;
            l0 = listo_cnt;
            start_burst(m, d, c, s);
            wait_cycles(45);
            check("mix_listo", listo_cnt - l0, 1);
            check("mix_len", listo_cyc - s, exp_len);
        end
        check("protocol", proto_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
